// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and IF/ID record type for the pipelined core
package riscv_pkg;
   localparam int PC_W = 9;
   localparam int INS_W = 32;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic             valid;
      logic [INS_W-1:0] instr;
      logic [PC_W-1:0]  pc;
      logic [PC_W-1:0]  pc_plus4;
   } if_id_t;
endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - pipeline register with async reset value, enable and sync flush
module pipe_reg #(
   parameter int W = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         flush,
   input  logic [W-1:0] flush_val,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // Flush beats enable so a squash is never held off by a stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= RST_VAL;
      else if (flush)
         q <= flush_val;
      else if (en)
         q <= d;
   end
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC register, imem handshake, IF/ID register
module if_stage #(
   parameter int PC_W = riscv_pkg::PC_W,
   parameter int INS_W = riscv_pkg::INS_W,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [INS_W-1:0] NOP_INSTR = INS_W'(riscv_pkg::NOP_INSTR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect,
   input  logic [PC_W-1:0]  redirect_pc,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_gnt,
   input  logic [INS_W-1:0] imem_rdata,
   output logic             id_valid,
   output logic [INS_W-1:0] id_instr,
   output logic [PC_W-1:0]  id_pc,
   output logic [PC_W-1:0]  id_pc_plus4,
   output logic             misaligned
);
   import riscv_pkg::*;

   // Same layout as riscv_pkg::if_id_t, but sized by this instance's parameters.
   typedef struct packed {
      logic             valid;
      logic [INS_W-1:0] instr;
      logic [PC_W-1:0]  pc;
      logic [PC_W-1:0]  pc_plus4;
   } if_id_p_t;

   localparam if_id_p_t IF_ID_RST = '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc_plus4: '0};

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_plus4;
   logic            mis_q;
   if_id_p_t        if_id_q;
   if_id_p_t        if_id_d;
   if_id_p_t        if_id_bubble;

   assign pc_plus4  = pc + PC_W'(4);
   assign imem_addr = pc;
   assign imem_req  = ~stall | redirect;

   // A bubble keeps the last id_pc/id_pc_plus4 and only kills valid/instr.
   always_comb begin
      if_id_bubble       = if_id_q;
      if_id_bubble.valid = 1'b0;
      if_id_bubble.instr = NOP_INSTR;
      if (imem_gnt)
         if_id_d = '{valid: 1'b1, instr: imem_rdata, pc: pc, pc_plus4: pc_plus4};
      else
         if_id_d = if_id_bubble;
   end

   pipe_reg #(
      .W       ($bits(if_id_p_t)),
      .RST_VAL (IF_ID_RST)
   ) u_if_id (
      .clk       (clk),
      .reset     (reset),
      .en        (~stall),
      .flush     (redirect),
      .flush_val (if_id_bubble),
      .d         (if_id_d),
      .q         (if_id_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc    <= RESET_PC;
         mis_q <= 1'b0;
      end else if (redirect) begin
         pc    <= {redirect_pc[PC_W-1:2], 2'b00};
         mis_q <= |redirect_pc[1:0];
      end else begin
         mis_q <= 1'b0;
         if (!stall && imem_gnt)
            pc <= pc_plus4;
      end
   end

   assign id_valid    = if_id_q.valid;
   assign id_instr    = if_id_q.instr;
   assign id_pc       = if_id_q.pc;
   assign id_pc_plus4 = if_id_q.pc_plus4;
   assign misaligned  = mis_q;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - table-driven self-checking bench for if_stage
module tb_if_stage;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [8:0]  redirect_pc;
   logic        imem_req;
   logic [8:0]  imem_addr;
   logic        imem_gnt;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [8:0]  id_pc;
   logic [8:0]  id_pc_plus4;
   logic        misaligned;

   int checks = 0;
   int errors = 0;

   if_stage #(.PC_W(9), .INS_W(32), .RESET_PC(9'h000), .NOP_INSTR(32'h00000013)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_pc_plus4 (id_pc_plus4),
      .misaligned  (misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [8:0]  rpc;
      logic        gnt;
      logic [31:0] rdata;
      logic        req;
      logic [8:0]  pc;
      logic        v;
      logic [31:0] instr;
      logic [8:0]  idpc;
      logic [8:0]  idp4;
      logic        mis;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, input logic rd, input logic [8:0] rpc, input logic g,
                      input logic [31:0] rdat, input logic rq, input logic [8:0] p,
                      input logic v, input logic [31:0] ins, input logic [8:0] ip,
                      input logic [8:0] ip4, input logic m);
      vec_t t;
      t.stall = st; t.redirect = rd; t.rpc = rpc; t.gnt = g; t.rdata = rdat;
      t.req = rq; t.pc = p; t.v = v; t.instr = ins; t.idpc = ip; t.idp4 = ip4; t.mis = m;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pc"}, 0, 32'(imem_addr), 32'h0);
      check({tag, "_valid"}, 0, 32'(id_valid), 32'h0);
      check({tag, "_instr"}, 0, id_instr, NOP);
      check({tag, "_idpc"}, 0, 32'(id_pc), 32'h0);
      check({tag, "_idp4"}, 0, 32'(id_pc_plus4), 32'h0);
      check({tag, "_mis"}, 0, 32'(misaligned), 32'h0);
   endtask

   initial begin
      //   stall redir rpc     gnt rdata         req pc      v  instr         idpc    idp4    mis
      add(0, 0, 9'h000, 1, 32'h00500093, 1, 9'h004, 1, 32'h00500093, 9'h000, 9'h004, 0);
      add(0, 0, 9'h000, 1, 32'h00100113, 1, 9'h008, 1, 32'h00100113, 9'h004, 9'h008, 0);
      add(1, 0, 9'h000, 1, 32'hdeadbeef, 0, 9'h008, 1, 32'h00100113, 9'h004, 9'h008, 0);
      add(1, 0, 9'h000, 1, 32'hdeadbeef, 0, 9'h008, 1, 32'h00100113, 9'h004, 9'h008, 0);
      add(1, 0, 9'h000, 1, 32'hdeadbeef, 0, 9'h008, 1, 32'h00100113, 9'h004, 9'h008, 0);
      add(0, 0, 9'h000, 1, 32'h00208193, 1, 9'h00c, 1, 32'h00208193, 9'h008, 9'h00c, 0);
      add(1, 1, 9'h040, 1, 32'hcafef00d, 1, 9'h040, 0, NOP,          9'h008, 9'h00c, 0);
      add(0, 1, 9'h042, 1, 32'hcafef00d, 1, 9'h040, 0, NOP,          9'h008, 9'h00c, 1);
      add(0, 0, 9'h000, 1, 32'h11111111, 1, 9'h044, 1, 32'h11111111, 9'h040, 9'h044, 0);
      add(0, 1, 9'h010, 1, 32'h99999999, 1, 9'h010, 0, NOP,          9'h040, 9'h044, 0);
      add(0, 0, 9'h000, 0, 32'h55555555, 1, 9'h010, 0, NOP,          9'h040, 9'h044, 0);
      add(0, 0, 9'h000, 0, 32'h55555555, 1, 9'h010, 0, NOP,          9'h040, 9'h044, 0);
      add(0, 0, 9'h000, 1, 32'h22222222, 1, 9'h014, 1, 32'h22222222, 9'h010, 9'h014, 0);
      add(0, 0, 9'h000, 0, 32'h66666666, 1, 9'h014, 0, NOP,          9'h010, 9'h014, 0);
      add(0, 1, 9'h1fc, 0, 32'h66666666, 1, 9'h1fc, 0, NOP,          9'h010, 9'h014, 0);
      add(0, 0, 9'h000, 1, 32'h33333333, 1, 9'h000, 1, 32'h33333333, 9'h1fc, 9'h000, 0);
      add(0, 0, 9'h000, 1, 32'h44444444, 1, 9'h004, 1, 32'h44444444, 9'h000, 9'h004, 0);
      add(0, 1, 9'h1ff, 1, 32'h77777777, 1, 9'h1fc, 0, NOP,          9'h000, 9'h004, 1);

      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_gnt = 1'b0; imem_rdata = '0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         stall = vecs[i].stall; redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
         imem_gnt = vecs[i].gnt; imem_rdata = vecs[i].rdata;
         #1;
         check("imem_req", i, 32'(imem_req), 32'(vecs[i].req));
         @(posedge clk);
         #1;
         check("pc", i, 32'(imem_addr), 32'(vecs[i].pc));
         check("id_valid", i, 32'(id_valid), 32'(vecs[i].v));
         check("id_instr", i, id_instr, vecs[i].instr);
         check("id_pc", i, 32'(id_pc), 32'(vecs[i].idpc));
         check("id_pc_plus4", i, 32'(id_pc_plus4), 32'(vecs[i].idp4));
         check("misaligned", i, 32'(misaligned), 32'(vecs[i].mis));
      end

      // Misaligned pulse lasts one cycle: quiet cycle with no grant clears it.
      @(negedge clk);
      redirect = 1'b0; stall = 1'b0; imem_gnt = 1'b0;
      @(posedge clk);
      #1;
      check("mis_pulse_end", 0, 32'(misaligned), 32'h0);
      check("mis_pulse_pc", 0, 32'(imem_addr), 32'h1fc);

      // Load a valid instruction, then assert reset between edges.
      @(negedge clk);
      imem_gnt = 1'b1; imem_rdata = 32'h88888888;
      @(posedge clk);
      #1;
      check("pre_async_valid", 0, 32'(id_valid), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("async");

      @(negedge clk);
      reset = 1'b0; imem_gnt = 1'b1; imem_rdata = 32'h00500093;
      @(posedge clk);
      #1;
      check("post_reset_idpc", 0, 32'(id_pc), 32'h0);
      check("post_reset_instr", 0, id_instr, 32'h00500093);
      check("post_reset_pc", 0, 32'(imem_addr), 32'h004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Parametrised instruction-fetch stage for the pipelined RISC-V core; successor to the single-cycle PC/next-PC path.
- Owns the PC register and PC+4 generation, and accepts redirects (branch/jal/jalr) from EX.
- Handshakes with instruction memory and drives the IF/ID pipeline register with valid, stall and flush control.
- Feeds the decode stage.

Parameters:
- PC_W, 9, PC/byte-address width.
- INS_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect  in  1  EX: branch taken or jump.
- redirect_pc  in  PC_W  EX: target address.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (byte address).
- imem_gnt  in  1  imem accepts the request this cycle.
- imem_rdata  in  INS_W  instruction, valid in the same cycle as imem_gnt.
- id_valid  out  1  IF/ID holds a real instruction.
- id_instr  out  INS_W  IF/ID instruction.
- id_pc  out  PC_W  IF/ID instruction address.
- id_pc_plus4  out  PC_W  IF/ID PC+4 (jal/jalr link value).
- misaligned  out  1  one-cycle pulse: redirect target not word-aligned.

Behaviour:
- Reset (async, active-high):
  - pc=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, misaligned=0.
  - Reset asserted mid-fetch discards everything; there is no pending state.
- Combinational outputs:
  - imem_addr = pc.
  - imem_req = ~stall | redirect.
- Widths: pc_plus4 = pc + 4, modulo 2^PC_W. Wrap-around from the top address to 0 is legal and silent.
- State per cycle, in priority order:
  1. redirect=1 (overrides stall):
     - pc <= {redirect_pc[PC_W-1:2],2'b00}.
     - IF/ID flushed: id_valid<=0, id_instr<=NOP_INSTR.
     - The imem response this cycle is discarded.
     - misaligned <= |redirect_pc[1:0].
  2. stall=1: pc and all IF/ID registers hold; misaligned<=0.
  3. imem_gnt=1:
     - pc <= pc_plus4.
     - id_valid<=1, id_instr<=imem_rdata, id_pc<=pc, id_pc_plus4<=pc_plus4.
     - misaligned<=0.
  4. imem_gnt=0:
     - pc holds.
     - Bubble inserted: id_valid<=0, id_instr<=NOP_INSTR; id_pc and id_pc_plus4 hold.
     - misaligned<=0.
- Latency: instruction at pc appears on id_* one cycle after its grant.
- Throughput: one instruction per cycle with continuous grant and no stall.
- Redirect and stall in the same cycle: redirect wins; the stalled IF/ID content is squashed.
- The fetch sequence is two-state implicit (RUN, BUBBLE); the state is encoded by id_valid and needs no extra FSM register.

Decomposition:
- Shared package riscv_pkg: NOP_INSTR constant, PC_W default, and a typedef struct if_id_t {valid, instr, pc, pc_plus4}.
- One natural sub-module: pipe_reg, a parametrised-width register with async reset value, enable (=~stall) and synchronous flush-to-value.
- if_stage instantiates pipe_reg for if_id_t and a plain register for pc.

Test Plan:
- Reset, then grant held high, imem returns 0x00500093 at 0, 0x00100113 at 4 -> cycle 1: id_pc=0, id_instr=0x00500093; cycle 2: id_pc=4, id_pc_plus4=8.
- Stall for 3 cycles at pc=8 -> imem_addr stays 8, id_* frozen, imem_req=0; on release, fetch resumes at 8.
- redirect=1, redirect_pc=0x40, together with stall=1 -> next cycle pc=0x40, id_valid=0, id_instr=0x00000013, misaligned=0.
- redirect_pc=0x42 -> pc=0x40, misaligned=1 for exactly one cycle.
- imem_gnt=0 for 2 cycles at pc=0x10 -> id_valid=0 for two cycles, pc stays 0x10; grant resumes -> id_pc=0x10.
- Wrap: pc=0x1FC with PC_W=9 and a grant -> id_pc_plus4=0x000, next pc=0x000.
- Reset asserted mid-stream between clock edges -> all outputs take their reset values immediately (asynchronously).
